ps2_scancode_display: RTL and testbench

// - Downstream stage of the PS/2 byte receiver. Consumes raw scan-code bytes (CODE_IN plus a

---
 rtl/ps2_scancode_display.sv | 193 +++++++++++++++++++
 tb/tb_ps2_scancode_display.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_display.sv
// PS/2 set-2 scan-code decoder with make/break events and a 4-digit hex display.
// Optional macro PS2_BREAK_DISP_EN: break events also shift the display.
module ps2_scancode_display #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DIGIT_HZ        = 1_000,
    parameter bit SEG_ACTIVE_LOW  = 1'b1,
    parameter bit DISP_ACTIVE_LOW = 1'b1
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [7:0] CODE_IN,
    input  logic       CODE_VALID,
    output logic       KEY_MAKE,
    output logic       KEY_BREAK,
    output logic [7:0] KEY_CODE,
    output logic       KEY_EXT,
    output logic [7:0] LED,
    output logic [6:0] SEG,
    output logic [3:0] DISP
);

    localparam int DIV = (CLK_HZ / DIGIT_HZ > 1) ? CLK_HZ / DIGIT_HZ : 1;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [6:0] SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0] DISP_OFF = DISP_ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    state_t        state;
    logic          valid_q;
    logic [2:0]    pause_cnt;
    logic [15:0]   disp_val;
    logic          key_make_q;
    logic          key_break_q;
    logic [7:0]    key_code_q;
    logic          key_ext_q;
    logic [7:0]    led_q;

    logic          accept;
    logic          is_e0;
    logic          is_f0;
    logic          is_e1;
    logic          is_ign;
    logic          has_ext;
    logic          has_brk;

    // Byte classification and rising-edge acceptance of CODE_VALID.
    always_comb begin
        accept  = CODE_VALID & ~valid_q;
        is_e0   = (CODE_IN == 8'hE0);
        is_f0   = (CODE_IN == 8'hF0);
        is_e1   = (CODE_IN == 8'hE1);
        is_ign  = (CODE_IN == 8'h00) || (CODE_IN == 8'hAA) ||
                  (CODE_IN == 8'hEE) || (CODE_IN == 8'hFA) ||
                  (CODE_IN >= 8'hFC);
        has_ext = (state == S_EXT) || (state == S_EXT_BRK);
        has_brk = (state == S_BRK) || (state == S_EXT_BRK);
    end

    // Prefix FSM, key event pulses, LED and the shifted display value.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state       <= S_IDLE;
            valid_q     <= 1'b0;
            pause_cnt   <= 3'd0;
            disp_val    <= 16'h0000;
            key_make_q  <= 1'b0;
            key_break_q <= 1'b0;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            led_q       <= 8'h00;
        end else begin
            valid_q     <= CODE_VALID;
            key_make_q  <= 1'b0;
            key_break_q <= 1'b0;
            if (accept) begin
                led_q <= CODE_IN;
                if (state == S_PAUSE) begin
                    pause_cnt <= pause_cnt - 3'd1;
                    if (pause_cnt == 3'd1) begin
                        state      <= S_IDLE;
                        key_make_q <= 1'b1;
                        key_code_q <= 8'hE1;
                        key_ext_q  <= 1'b0;
                        disp_val   <= {disp_val[7:0], 8'hE1};
                    end
                end else begin
                    unique case (1'b1)
                        is_e0: state <= has_brk ? S_EXT_BRK : S_EXT;
                        is_f0: state <= has_ext ? S_EXT_BRK : S_BRK;
                        is_e1: begin
                            state     <= S_PAUSE;
                            pause_cnt <= 3'd7;
                        end
                        is_ign: state <= S_IDLE;
                        default: begin
                            state      <= S_IDLE;
                            key_code_q <= CODE_IN;
                            key_ext_q  <= has_ext;
                            if (has_brk) begin
                                key_break_q <= 1'b1;
`ifdef PS2_BREAK_DISP_EN
                                disp_val <= {disp_val[7:0], CODE_IN};
`else
                                disp_val <= disp_val;
`endif
                            end else begin
                                key_make_q <= 1'b1;
                                disp_val   <= {disp_val[7:0], CODE_IN};
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign KEY_MAKE  = key_make_q;
    assign KEY_BREAK = key_break_q;
    assign KEY_CODE  = key_code_q;
    assign KEY_EXT   = key_ext_q;
    assign LED       = led_q;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        unique case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    logic [DW-1:0] div_cnt;
    logic [1:0]    digit_idx;
    logic [3:0]    nibble;
    logic [3:0]    onehot;
    logic [6:0]    seg_q;
    logic [3:0]    disp_q;

    // Select the nibble and enable for the current digit.
    always_comb begin
        nibble = disp_val[3:0];
        onehot = 4'b0001;
        unique case (digit_idx)
            2'd0: begin nibble = disp_val[3:0];   onehot = 4'b0001; end
            2'd1: begin nibble = disp_val[7:4];   onehot = 4'b0010; end
            2'd2: begin nibble = disp_val[11:8];  onehot = 4'b0100; end
            default: begin nibble = disp_val[15:12]; onehot = 4'b1000; end
        endcase
    end

    // Refresh divider, digit scan, and SEG/DISP registered together.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            div_cnt   <= '0;
            digit_idx <= 2'd0;
            seg_q     <= SEG_OFF;
            disp_q    <= DISP_OFF;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt   <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            seg_q  <= SEG_ACTIVE_LOW ? ~hex7(nibble) : hex7(nibble);
            disp_q <= DISP_ACTIVE_LOW ? ~onehot : onehot;
        end
    end

    assign SEG  = seg_q;
    assign DISP = disp_q;

endmodule

// File: tb/tb_ps2_scancode_display.sv
// Directed bench for ps2_scancode_display with an event scoreboard
// and a bench-side model of the 4-digit display contents.
module tb_ps2_scancode_display;

    localparam int PERIOD = 10;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic [7:0] CODE_IN = 8'h00;
    logic       CODE_VALID = 1'b0;
    logic       KEY_MAKE;
    logic       KEY_BREAK;
    logic [7:0] KEY_CODE;
    logic       KEY_EXT;
    logic [7:0] LED;
    logic [6:0] SEG;
    logic [3:0] DISP;

    int checks = 0;
    int errors = 0;

    logic [9:0]  sb[$];
    logic [15:0] exp_disp = 16'h0000;
    logic        prev_pulse = 1'b0;

    ps2_scancode_display #(
        .CLK_HZ(40),
        .DIGIT_HZ(4),
        .SEG_ACTIVE_LOW(1'b1),
        .DISP_ACTIVE_LOW(1'b1)
    ) dut (
        .CLK(CLK),
        .RSTN(RSTN),
        .CODE_IN(CODE_IN),
        .CODE_VALID(CODE_VALID),
        .KEY_MAKE(KEY_MAKE),
        .KEY_BREAK(KEY_BREAK),
        .KEY_CODE(KEY_CODE),
        .KEY_EXT(KEY_EXT),
        .LED(LED),
        .SEG(SEG),
        .DISP(DISP)
    );

    always #(PERIOD / 2) CLK = ~CLK;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
                               7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C,
                               7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Scoreboard: every KEY_MAKE/KEY_BREAK pulse must match the next
    // queued event, never both high, never two cycles in a row.
    always @(negedge CLK) begin
        logic       have;
        logic [9:0] want;
        logic [9:0] got;
        if (KEY_MAKE === 1'b1 || KEY_BREAK === 1'b1) begin
            have = (sb.size() > 0);
            want = have ? sb.pop_front() : 10'h3FF;
            got  = {KEY_BREAK, KEY_CODE, KEY_EXT};
            checks++;
            assert (have && !(KEY_MAKE && KEY_BREAK) && !prev_pulse &&
                    got === want) else begin
                errors++;
                $error("FAIL event got=%h(m%0b) want=%h queued=%0b prev=%0b",
                       got, KEY_MAKE, want, have, prev_pulse);
            end
        end
        prev_pulse = KEY_MAKE | KEY_BREAK;
    end

    task automatic exp_make(input logic [7:0] c, input logic e);
        sb.push_back({1'b0, c, e});
        exp_disp = {exp_disp[7:0], c};
    endtask

    task automatic exp_break(input logic [7:0] c, input logic e);
        sb.push_back({1'b1, c, e});
`ifdef PS2_BREAK_DISP_EN
        exp_disp = {exp_disp[7:0], c};
`endif
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge CLK);
        CODE_IN    = b;
        CODE_VALID = 1'b1;
        @(negedge CLK);
        CODE_VALID = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic do_reset(input int n);
        @(negedge CLK);
        RSTN = 1'b0;
        repeat (n) @(negedge CLK);
        exp_disp = 16'h0000;
        RSTN = 1'b1;
    endtask

    task automatic check_display(input string tag);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] want_disp;
            logic [3:0] nib;
            int n;
            want_disp = ~(4'b0001 << d);
            nib = exp_disp[4*d +: 4];
            n = 0;
            while (DISP !== want_disp && n < 60) begin
                @(negedge CLK);
                n++;
            end
            chk($sformatf("%s_d%0d", tag, d),
                {5'd0, DISP, SEG}, {5'd0, want_disp, ~seg7(nib)});
        end
    endtask

    initial begin
        int n;
        // reset state
        RSTN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_key", {13'd0, KEY_MAKE, KEY_BREAK, KEY_EXT}, 16'd0);
        chk("rst_code", {8'd0, KEY_CODE}, 16'h0000);
        chk("rst_led", {8'd0, LED}, 16'h0000);
        chk("rst_seg_disp", {5'd0, DISP, SEG}, {5'd0, 4'hF, 7'h7F});
        RSTN = 1'b1;
        @(negedge CLK);
        chk("first_disp", {12'd0, DISP}, {12'd0, 4'b1110});

        // digit period
        n = 0;
        while (DISP !== 4'b1101 && n < 40) begin @(negedge CLK); n++; end
        n = 0;
        while (DISP === 4'b1101 && n < 40) begin @(negedge CLK); n++; end
        chk("digit_period", 16'(n), 16'd10);
        chk("next_digit", {12'd0, DISP}, {12'd0, 4'b1011});
        check_display("disp_reset");

        // simple make
        exp_make(8'h1C, 1'b0);
        send(8'h1C);
        chk("make_led", {8'd0, LED}, 16'h001C);
        chk("make_code", {7'd0, KEY_CODE, KEY_EXT}, {7'd0, 8'h1C, 1'b0});
        check_display("disp_1c");

        // break
        send(8'hF0);
        exp_break(8'h1C, 1'b0);
        send(8'h1C);
        check_display("disp_brk");

        // extended make and break
        send(8'hE0);
        exp_make(8'h75, 1'b1);
        send(8'h75);
        chk("ext_make", {7'd0, KEY_CODE, KEY_EXT}, {7'd0, 8'h75, 1'b1});
        send(8'hE0);
        send(8'hF0);
        exp_break(8'h75, 1'b1);
        send(8'h75);
        chk("ext_brk", {7'd0, KEY_CODE, KEY_EXT}, {7'd0, 8'h75, 1'b1});
        check_display("disp_ext");

        // pause sequence
        send(8'hE1);
        send(8'h14);
        send(8'h77);
        send(8'hE1);
        send(8'hF0);
        send(8'h14);
        send(8'hF0);
        exp_make(8'hE1, 1'b0);
        send(8'h77);
        chk("pause_led", {8'd0, LED}, 16'h0077);
        chk("pause_code", {7'd0, KEY_CODE, KEY_EXT}, {7'd0, 8'hE1, 1'b0});
        check_display("disp_pause");

        // held level counts once
        exp_make(8'h1C, 1'b0);
        @(negedge CLK);
        CODE_IN    = 8'h1C;
        CODE_VALID = 1'b1;
        repeat (20) @(negedge CLK);
        CODE_VALID = 1'b0;
        repeat (3) @(negedge CLK);

        // ignored byte after F0 cancels the break prefix
        send(8'hF0);
        send(8'h00);
        exp_make(8'h5A, 1'b0);
        send(8'h5A);

        // reset discards pending prefix
        send(8'hE0);
        do_reset(1);
        @(negedge CLK);
        chk("midrst_led", {8'd0, LED}, 16'h0000);
        exp_make(8'h75, 1'b0);
        send(8'h75);
        chk("midrst_code", {7'd0, KEY_CODE, KEY_EXT}, {7'd0, 8'h75, 1'b0});
        check_display("disp_midrst");

        // acknowledge byte: no event
        send(8'hFA);
        chk("fa_led", {8'd0, LED}, 16'h00FA);
        chk("fa_code", {8'd0, KEY_CODE}, 16'h0075);

        repeat (5) @(negedge CLK);
        chk("sb_empty", 16'(sb.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
